// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction RAM between the fetch stage and the program loader.
// Fetch is held off until loading completes; afterwards the loader has priority with a fetch starvation bound.
module imem_arbiter #(
  parameter int ADDR_SIZE  = 10,
  parameter int WORD_SIZE  = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 ld_req,
  input  logic                 ld_we,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0] ld_wdata,
  input  logic                 ld_done,
  output logic                 ld_gnt,
  output logic                 ld_rvalid,
  output logic [WORD_SIZE-1:0] ld_rdata,
  output logic                 running,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t     state;
  logic [3:0] streak;

  // Loader wins contention until it has taken STREAK_MAX grants in a row over a waiting fetch.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (state == BOOT) begin
      ld_gnt = ld_req;
    end else if (if_req && ld_req) begin
      if (streak == STREAK_MAX) if_gnt = 1'b1;
      else                      ld_gnt = 1'b1;
    end else begin
      if_gnt = if_req;
      ld_gnt = ld_req;
    end
  end

  assign mem_en    = if_gnt | ld_gnt;
  assign mem_we    = ld_gnt & ld_we;
  assign mem_addr  = ld_gnt ? ld_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = ld_gnt ? ld_wdata : '0;

  // Both read ports see the RAM output; the per-owner rvalid flops act as the return tag.
  assign if_rdata = mem_rdata;
  assign ld_rdata = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      running   <= 1'b0;
      streak    <= 4'd0;
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      ld_rvalid <= ld_gnt & ~ld_we;
      if (state == BOOT) begin
        if (ld_done) begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else begin
        if (if_gnt || !if_req)
          streak <= 4'd0;
        else if (ld_gnt && streak != STREAK_MAX)
          streak <= streak + 4'd1;
      end
    end
  end

endmodule
